approx_divider: RTL and testbench
=================================

APPROX_DIVIDER -- requirements
Module: approx_divider

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-low reset, named clk and rst as in the rest of the codebase.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  synchronous active-low reset; sampled on rising clk.
REQ-004 start  input  1  request pulse; sampled only in IDLE.
REQ-005 N  input  16  unsigned dividend; captured on the accepted start edge.
REQ-006 D  input  16  unsigned divisor; captured on the accepted start edge.
REQ-007 Y  output  16  approximate quotient; held until the next accepted start.
REQ-008 busy  output  1  high from the cycle after an accepted start until done.
REQ-009 done  output  1  one-cycle pulse marking Y valid.
REQ-010 div_by_zero  output  1  set with done when D==0; held until the next accepted start.

Function
REQ-011 States SHALL be IDLE, NORM, DIV, ADJ and DONE.
REQ-012 In IDLE, start=1 SHALL capture N and D, clear both leading-zero counters cntN and cntD, and clear div_by_zero.
REQ-013 From IDLE:
- D==0 SHALL go to DONE with Y=16'hFFFF and div_by_zero=1; this includes N==0.
- Otherwise N==0 SHALL go to DONE with Y=0.
- Otherwise the next state SHALL be NORM.
REQ-014 NORM SHALL, each cycle, left-shift each operand register whose bit 15 is 0 and increment its counter.
- When both bit 15s are 1, NORM SHALL go to DIV without shifting.
- NORM therefore takes max(cntN,cntD)+1 cycles.
REQ-015 The dividend byte n8 and divisor byte d8 SHALL be bits [15:8] of the normalised registers; both lie in 128..255.
REQ-016 DIV SHALL run exactly 8 cycles of restoring division with a 9-bit remainder initialised to n8.
- Cycle 0: if rem>=d8, set q[7] and subtract d8.
- Cycles 1..7: rem<<=1, then compare and subtract to produce q[6:0] MSB-first.
- Result: q = floor(n8*128/d8), range 64..255.
REQ-017 On entry to ADJ the signed shift s = cntD - cntN - 7 SHALL be computed; range -22..+8.
REQ-018 ADJ SHALL shift a 16-bit result register, initialised to {8'b0,q}, by one bit per cycle.
- s<0: logical right shift, |s| times.
- s>0: left shift, s times.
- Then go to DONE; ADJ takes |s|+1 cycles.
- No overflow is possible: q<256 and s<=8.
REQ-019 DONE SHALL last one cycle:
- done=1 and busy=0; Y updates from the result register on entry to DONE.
- The next state is IDLE.
REQ-020 Latency SHALL be exactly max(cntN,cntD)+|s|+11 cycles from the start edge to done; zero-operand cases take exactly 1 cycle.
REQ-021 start while busy, or during DONE, SHALL be ignored.
- start in the cycle after DONE, in IDLE, SHALL be accepted.
REQ-022 N and D changing after capture SHALL have no effect.

Reset
REQ-023 rst=0 at a rising edge SHALL force IDLE, Y=0, busy=0, done=0, div_by_zero=0, and clear both counters and all datapath registers.
REQ-024 Reset in any state, including mid-NORM, DIV or ADJ, SHALL abort the operation with no done pulse; start SHALL be accepted in the first cycle after rst returns to 1.

Structure
REQ-025 The state encoding, the 16-bit operand width, the 8-bit mantissa width and the DIV iteration count of 8 SHALL live in the shared project package/header.
REQ-026 Normalisation SHALL be one reusable sub-module, norm_shift16, instantiated twice: a loadable 16-bit left shifter with leading-zero counter and MSB flag.
- Quotient loop, ADJ shifter and FSM SHALL stay in approx_divider.

Verification
REQ-027 N=1000, D=10 -> n8=250, d8=160, q=200, s=-1; Y=100 after 24 cycles, one done pulse.
REQ-028 N=16'h8000, D=16'h8000 -> q=128, s=-7; Y=1 after 18 cycles.
REQ-029 N=65535, D=1 -> q=255, s=+8; Y=16'hFF00 after 34 cycles; N=1, D=65535 -> q=64, s=-22; Y=0 after 48 cycles.
REQ-030 D=0 with N=1234, then N=0 with D=0 -> both: Y=16'hFFFF, div_by_zero=1, done 1 cycle after start; N=0, D=7 -> Y=0, div_by_zero=0.
REQ-031 Start N=1000, D=10, pulse start again at cycles 3 and 10, assert rst=0 at cycle 15 -> second starts ignored, no done, Y=0, IDLE; a new start with N=1000, D=10 after rst=1 gives Y=100.

Source files
------------

// File: rtl/approx_divider_pkg.sv
// approx_divider_pkg: shared widths, state encoding and iteration count for approx_divider.
package approx_divider_pkg;
   localparam int W = 16;
   localparam int M = 8;
   localparam int DIV_ITERS = 8;
   localparam int CW = $clog2(W) + 1;
   localparam int IW = $clog2(DIV_ITERS);
   typedef enum logic [2:0] {IDLE, NORM, DIV, ADJ, DONE} state_t;
endpackage

// File: rtl/approx_divider_norm_shift16.sv
// norm_shift16: loadable 16-bit left shifter that normalises an operand and counts its leading zeros.
module norm_shift16
   import approx_divider_pkg::*;
(
   input  logic          clk,
   input  logic          rst,
   input  logic          load_i,
   input  logic [W-1:0]  din_i,
   input  logic          shift_i,
   output logic [M-1:0]  man_o,
   output logic [CW-1:0] cnt_o,
   output logic          msb_o
);
   logic [W-1:0]  val_q, val_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          step;
   assign step = shift_i && !val_q[W-1];
   always_comb begin
      val_d = load_i ? din_i : step ? val_q << 1 : val_q;
      cnt_d = load_i ? '0 : step ? cnt_q + 1'b1 : cnt_q;
   end
   always_ff @(posedge clk) begin
      if (!rst) begin
         val_q <= '0;
         cnt_q <= '0;
      end else begin
         val_q <= val_d;
         cnt_q <= cnt_d;
      end
   end
   assign man_o = val_q[W-1 -: M];
   assign cnt_o = cnt_q;
   assign msb_o = val_q[W-1];
endmodule

// File: rtl/approx_divider.sv
// approx_divider: 16-bit approximate divider using normalised 8-bit mantissas,
// an 8-step restoring quotient loop and a final exponent shift.
module approx_divider
   import approx_divider_pkg::*;
(
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic [W-1:0] N,
   input  logic [W-1:0] D,
   output logic [W-1:0] Y,
   output logic         busy,
   output logic         done,
   output logic         div_by_zero
);
   state_t        state_q, state_d;
   logic [M:0]    rem_q, rem_d;
   logic [M-1:0]  quo_q, quo_d;
   logic [IW-1:0] it_q, it_d;
   logic [W-1:0]  res_q, res_d;
   logic [CW-1:0] sh_q, sh_d;
   logic          left_q, left_d;
   logic [W-1:0]  y_q, y_d;
   logic          dbz_q, dbz_d;
   logic [M-1:0]  n_man, d_man;
   logic [CW-1:0] n_cnt, d_cnt;
   logic          n_msb, d_msb, load;
   logic [M:0]    trial;
   logic          ge;
   logic [CW:0]   s;
   assign load = (state_q == IDLE) && start;
   norm_shift16 u_norm_n (
      .clk(clk), .rst(rst), .load_i(load), .din_i(N), .shift_i(state_q == NORM),
      .man_o(n_man), .cnt_o(n_cnt), .msb_o(n_msb)
   );
   norm_shift16 u_norm_d (
      .clk(clk), .rst(rst), .load_i(load), .din_i(D), .shift_i(state_q == NORM),
      .man_o(d_man), .cnt_o(d_cnt), .msb_o(d_msb)
   );
   always_comb begin
      state_d = state_q;
      rem_d   = rem_q;
      quo_d   = quo_q;
      it_d    = it_q;
      res_d   = res_q;
      sh_d    = sh_q;
      left_d  = left_q;
      y_d     = y_q;
      dbz_d   = dbz_q;
      // the first quotient step compares the unshifted mantissa, later steps shift first
      trial   = (it_q == '0) ? rem_q : {rem_q[M-1:0], 1'b0};
      ge      = trial >= {1'b0, d_man};
      s       = {1'b0, d_cnt} - {1'b0, n_cnt} - (CW+1)'(M-1);
      unique case (state_q)
         IDLE: if (start) begin
            dbz_d = (D == '0);
            if (D == '0) begin
               state_d = DONE;
               y_d     = '1;
            end else if (N == '0) begin
               state_d = DONE;
               y_d     = '0;
            end else state_d = NORM;
         end
         NORM: if (n_msb && d_msb) begin
            state_d = DIV;
            rem_d   = {1'b0, n_man};
            quo_d   = '0;
            it_d    = '0;
         end
         DIV: begin
            rem_d = ge ? trial - {1'b0, d_man} : trial;
            quo_d = {quo_q[M-2:0], ge};
            it_d  = it_q + 1'b1;
            if (it_q == IW'(DIV_ITERS-1)) begin
               state_d = ADJ;
               res_d   = {{(W-M){1'b0}}, quo_d};
               left_d  = !s[CW];
               sh_d    = s[CW] ? CW'(-s) : CW'(s);
            end
         end
         ADJ: if (sh_q == '0) begin
            state_d = DONE;
            y_d     = res_q;
         end else begin
            sh_d  = sh_q - 1'b1;
            res_d = left_q ? res_q << 1 : res_q >> 1;
         end
         DONE: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= IDLE;
         rem_q   <= '0;
         quo_q   <= '0;
         it_q    <= '0;
         res_q   <= '0;
         sh_q    <= '0;
         left_q  <= 1'b0;
         y_q     <= '0;
         dbz_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         rem_q   <= rem_d;
         quo_q   <= quo_d;
         it_q    <= it_d;
         res_q   <= res_d;
         sh_q    <= sh_d;
         left_q  <= left_d;
         y_q     <= y_d;
         dbz_q   <= dbz_d;
      end
   end
   assign Y           = y_q;
   assign busy        = (state_q == NORM) || (state_q == DIV) || (state_q == ADJ);
   assign done        = (state_q == DONE);
   assign div_by_zero = dbz_q;
endmodule

// File: tb/tb_approx_divider.sv
// tb_approx_divider: directed checks of quotient, latency, zero operands, back-to-back starts and abort.
module tb_approx_divider;
   logic        clk = 1'b0, rst = 1'b0, start = 1'b0;
   logic [15:0] N = '0, D = '0, Y;
   logic        busy, done, div_by_zero;
   int          checks = 0, fails = 0;

   approx_divider dut (
      .clk(clk), .rst(rst), .start(start), .N(N), .D(D),
      .Y(Y), .busy(busy), .done(done), .div_by_zero(div_by_zero)
   );

   always #5 clk = ~clk;

   // called at a negedge; returns at the negedge where done is seen, lat counts the start edge as 1
   task automatic do_op(input logic [15:0] n, input logic [15:0] d, output int lat);
      N = n;
      D = d;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      N = 16'($urandom);
      D = 16'($urandom);
      lat = 1;
      while (!done && lat < 200) begin
         @(negedge clk);
         lat++;
      end
      if (!done) lat = -1;
   endtask

   task automatic test_reset;
      rst = 1'b0;
      start = 1'b0;
      repeat (3) @(negedge clk);
      checks++;
      if (Y !== 16'h0 || busy !== 1'b0 || done !== 1'b0 || div_by_zero !== 1'b0) begin
         fails++;
         $display("FAIL reset: Y=%h busy=%b done=%b dbz=%b, want 0000/0/0/0", Y, busy, done, div_by_zero);
      end
      rst = 1'b1;
   endtask

   task automatic test_quotients;
      logic [15:0] tn [5] = '{16'd1000, 16'h8000, 16'hFFFF, 16'd1,    16'd50000};
      logic [15:0] td [5] = '{16'd10,   16'h8000, 16'd1,    16'hFFFF, 16'd300};
      logic [15:0] ty [5] = '{16'd100,  16'd1,    16'hFF00, 16'd0,    16'd166};
      int          tl [5] = '{24, 18, 34, 48, 18};
      int lat;
      for (int i = 0; i < 5; i++) begin
         do_op(tn[i], td[i], lat);
         checks++;
         if (lat !== tl[i]) begin
            fails++;
            $display("FAIL quot%0d latency: got %0d, want %0d", i, lat, tl[i]);
         end
         checks++;
         if (Y !== ty[i] || div_by_zero !== 1'b0 || busy !== 1'b0) begin
            fails++;
            $display("FAIL quot%0d result: Y=%h dbz=%b busy=%b, want Y=%h dbz=0 busy=0", i, Y, div_by_zero, busy, ty[i]);
         end
         @(negedge clk);
         checks++;
         if (done !== 1'b0 || Y !== ty[i]) begin
            fails++;
            $display("FAIL quot%0d pulse: done=%b Y=%h, want done=0 Y=%h", i, done, Y, ty[i]);
         end
      end
   endtask

   task automatic test_zero;
      int lat;
      do_op(16'd1234, 16'd0, lat);
      checks++;
      if (lat !== 1 || Y !== 16'hFFFF || div_by_zero !== 1'b1 || busy !== 1'b0) begin
         fails++;
         $display("FAIL dz_n1234: lat=%0d Y=%h dbz=%b busy=%b, want 1/FFFF/1/0", lat, Y, div_by_zero, busy);
      end
      @(negedge clk);
      checks++;
      if (done !== 1'b0 || div_by_zero !== 1'b1 || Y !== 16'hFFFF) begin
         fails++;
         $display("FAIL dz_hold: done=%b dbz=%b Y=%h, want 0/1/FFFF", done, div_by_zero, Y);
      end
      do_op(16'd0, 16'd0, lat);
      checks++;
      if (lat !== 1 || Y !== 16'hFFFF || div_by_zero !== 1'b1) begin
         fails++;
         $display("FAIL dz_n0: lat=%0d Y=%h dbz=%b, want 1/FFFF/1", lat, Y, div_by_zero);
      end
      @(negedge clk);
      do_op(16'd0, 16'd7, lat);
      checks++;
      if (lat !== 1 || Y !== 16'h0 || div_by_zero !== 1'b0) begin
         fails++;
         $display("FAIL n0_d7: lat=%0d Y=%h dbz=%b, want 1/0000/0", lat, Y, div_by_zero);
      end
      @(negedge clk);
   endtask

   task automatic test_back_to_back;
      int lat;
      do_op(16'd1000, 16'd10, lat);
      N = 16'd0;
      D = 16'd0;
      start = 1'b1;
      @(negedge clk);
      checks++;
      if (done !== 1'b0 || busy !== 1'b0 || div_by_zero !== 1'b0 || Y !== 16'd100) begin
         fails++;
         $display("FAIL b2b_ignore_done: done=%b busy=%b dbz=%b Y=%h, want 0/0/0/0064", done, busy, div_by_zero, Y);
      end
      do_op(16'd50000, 16'd300, lat);
      checks++;
      if (lat !== 18 || Y !== 16'd166 || div_by_zero !== 1'b0) begin
         fails++;
         $display("FAIL b2b_accept: lat=%0d Y=%h dbz=%b, want 18/00a6/0", lat, Y, div_by_zero);
      end
      @(negedge clk);
   endtask

   task automatic test_abort;
      int lat;
      bit saw_done = 1'b0;
      N = 16'd1000;
      D = 16'd10;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (int c = 1; c <= 15; c++) begin
         start = (c == 3 || c == 10);
         if (start) begin
            N = 16'd0;
            D = 16'd0;
         end
         rst = (c != 15);
         @(negedge clk);
         if (done) saw_done = 1'b1;
         if (c == 11) begin
            checks++;
            if (busy !== 1'b1 || div_by_zero !== 1'b0) begin
               fails++;
               $display("FAIL abort_busy: busy=%b dbz=%b, want 1/0", busy, div_by_zero);
            end
         end
      end
      start = 1'b0;
      checks++;
      if (saw_done || Y !== 16'h0 || busy !== 1'b0 || done !== 1'b0 || div_by_zero !== 1'b0) begin
         fails++;
         $display("FAIL abort_reset: saw_done=%b Y=%h busy=%b done=%b dbz=%b, want 0/0000/0/0/0", saw_done, Y, busy, done, div_by_zero);
      end
      rst = 1'b1;
      do_op(16'd1000, 16'd10, lat);
      checks++;
      if (lat !== 24 || Y !== 16'd100) begin
         fails++;
         $display("FAIL abort_restart: lat=%0d Y=%h, want 24/0064", lat, Y);
      end
      @(negedge clk);
   endtask

   initial begin
      test_reset();
      test_quotients();
      test_zero();
      test_back_to_back();
      test_abort();
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end
endmodule
